// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/response bundle between the execute-stage control and the
// iterative multiply/divide unit.
//
// Parameters:
//   WIDTH   operand width; HI and LO are each WIDTH bits
//
// Signals:
//   start   request a new operation (only sampled while busy=0)
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    rs / rt operands
//   flush   squash the in-flight operation
//   hi_wen  MTHI write strobe
//   lo_wen  MTLO write strobe
//   wdat    MTHI/MTLO write data
//   busy    operation in flight
//   done    one-cycle pulse when HI/LO hold a fresh result
//   hi, lo  result registers
//
// Modports: master (control side) drives requests, slave (the unit) drives
// busy/done/hi/lo.
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_wen;
    logic             lo_wen;
    logic [WIDTH-1:0] wdat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_wen, lo_wen, wdat,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_wen, lo_wen, wdat,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// MULT/MULTU use one radix-2 shift-add step per cycle, DIV/DIVU one
// restoring shift-subtract step per cycle, both on operand magnitudes; a
// final FIX cycle applies sign correction and writes HI/LO.
//
// Ports:
//   CLK   clock, all state on the rising edge
//   RST   asynchronous active-high reset
//   bus   mult_div_unit_if.slave (start/op/a/b/flush/hi_wen/lo_wen/wdat in,
//         busy/done/hi/lo out)
//
// Build option:
//   MDU_EARLY_OUT_EN  when defined, a multiply leaves CALC once the remaining
//                     multiplier bits are zero, and a divide by zero skips
//                     CALC entirely. Results are identical either way.
//
// Timing (default build): start sampled at edge N, busy from N+1 through the
// FIX cycle, done pulses in the cycle after edge N+WIDTH+1.
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               busy_r;
    logic               done_r;
    logic               busy_n_s;
    logic               done_n_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;      // mult: product; div: {remainder, quotient}
    logic [2*WIDTH-1:0] mcand_r;    // mult: shifted multiplicand; div: divisor in low half
    logic [WIDTH-1:0]   mplier_r;   // mult: multiplier bits not yet consumed
    logic [WIDTH-1:0]   a_raw_r;    // raw dividend, returned in HI on divide by zero
    logic               is_div_r;
    logic               div_zero_r;
    logic               neg_prod_r;
    logic               neg_quo_r;
    logic               neg_rem_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               accept_s;
    logic               signed_op_s;
    logic               div_zero_in_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               calc_last_s;
    logic [2*WIDTH-1:0] mult_acc_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] div_acc_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   hi_res_s;
    logic [WIDTH-1:0]   lo_res_s;
`ifdef MDU_EARLY_OUT_EN
    logic               mult_rest_zero_s;
`endif

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && x[WIDTH-1]) begin
            m = -x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Request decode: acceptance, signedness and operand magnitudes.
    always_comb begin
        signed_op_s   = ~bus.op[0];
        accept_s      = (state_r == IDLE) && bus.start && !bus.flush;
        div_zero_in_s = bus.op[1] && (bus.b == {WIDTH{1'b0}});
        a_mag_s       = magnitude(bus.a, signed_op_s);
        b_mag_s       = magnitude(bus.b, signed_op_s);
    end

    // Decide whether the current CALC cycle is the last iteration.
    always_comb begin
`ifdef MDU_EARLY_OUT_EN
        // Remaining multiplier bits after this step are all zero: product complete.
        mult_rest_zero_s = (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
        if (!is_div_r && mult_rest_zero_s) begin
            calc_last_s = 1'b1;
        end else begin
            calc_last_s = (cnt_r == CNT_ONE);
        end
`else
        calc_last_s = (cnt_r == CNT_ONE);
`endif
    end

    // FSM state register together with the registered busy/done outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= busy_n_s;
            done_r  <= done_n_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef MDU_EARLY_OUT_EN
                    if (div_zero_in_s) begin
                        next_state_s = FIX;
                    end else begin
                        next_state_s = CALC;
                    end
`else
                    next_state_s = CALC;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    next_state_s = IDLE;
                end else if (calc_last_s) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM output logic: next-cycle values of busy and done.
    always_comb begin
        busy_n_s = (next_state_s != IDLE);
        if ((state_r == FIX) && !bus.flush) begin
            done_n_s = 1'b1;
        end else begin
            done_n_s = 1'b0;
        end
    end

    // One iteration of shift-add (multiply) and restoring divide.
    always_comb begin
        if (mplier_r[0]) begin
            mult_acc_s = acc_r + mcand_r;
        end else begin
            mult_acc_s = acc_r;
        end
        // Shift the next dividend bit into the partial remainder and trial-subtract.
        div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, mcand_r[WIDTH-1:0]};
        if (!div_trial_s[WIDTH]) begin
            div_acc_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and selection of the value written to HI/LO in FIX.
    always_comb begin
        if (neg_prod_r) begin
            prod_s = -acc_r;
        end else begin
            prod_s = acc_r;
        end
        hi_res_s = prod_s[2*WIDTH-1:WIDTH];
        lo_res_s = prod_s[WIDTH-1:0];
        if (is_div_r) begin
            if (div_zero_r) begin
                hi_res_s = a_raw_r;
                lo_res_s = {WIDTH{1'b1}};
            end else begin
                // Remainder follows the dividend's sign; MIN / -1 wraps back to MIN.
                if (neg_rem_r) begin
                    hi_res_s = -acc_r[2*WIDTH-1:WIDTH];
                end else begin
                    hi_res_s = acc_r[2*WIDTH-1:WIDTH];
                end
                if (neg_quo_r) begin
                    lo_res_s = -acc_r[WIDTH-1:0];
                end else begin
                    lo_res_s = acc_r[WIDTH-1:0];
                end
            end
        end else begin
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end
    end

    // Iteration datapath: operand capture at start and per-cycle stepping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            mcand_r    <= {(2*WIDTH){1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            a_raw_r    <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            div_zero_r <= 1'b0;
            neg_prod_r <= 1'b0;
            neg_quo_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r      <= CNT_INIT;
                        a_raw_r    <= bus.a;
                        is_div_r   <= bus.op[1];
                        div_zero_r <= div_zero_in_s;
                        neg_prod_r <= (bus.op == 2'b00) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_quo_r  <= (bus.op == 2'b10) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_r  <= (bus.op == 2'b10) && bus.a[WIDTH-1];
                        if (bus.op[1]) begin
                            acc_r    <= {{WIDTH{1'b0}}, a_mag_s};
                            mcand_r  <= {{WIDTH{1'b0}}, b_mag_s};
                            mplier_r <= {WIDTH{1'b0}};
                        end else begin
                            acc_r    <= {(2*WIDTH){1'b0}};
                            mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
                            mplier_r <= b_mag_s;
                        end
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (is_div_r) begin
                        acc_r <= div_acc_s;
                    end else begin
                        acc_r    <= mult_acc_s;
                        mcand_r  <= mcand_r << 1'b1;
                        mplier_r <= mplier_r >> 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // HI/LO registers: result write on completion, MTHI/MTLO while idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if ((state_r == FIX) && !bus.flush) begin
            hi_r <= hi_res_s;
            lo_r <= lo_res_s;
        end else if (!busy_r) begin
            if (bus.hi_wen) begin
                hi_r <= bus.wdat;
            end
            if (bus.lo_wen) begin
                lo_r <= bus.wdat;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit at WIDTH=32: a table of directed
// vectors plus random operations feed a scoreboard queue; a monitor pops and
// compares HI/LO on every done pulse. Hand-written sequences cover MTHI/MTLO,
// flush, start-while-busy, same-edge write and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t           vecs [12];
    logic [2*W-1:0] sb_q [$];
    int             n_checks = 0;
    int             n_pass   = 0;

    function automatic void check(input string nm, input logic [2*W-1:0] act,
                                  input logic [2*W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Reference {hi, lo} from plain SystemVerilog arithmetic.
    function automatic logic [2*W-1:0] model(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sbv;
        logic signed [W-1:0]   qa;
        logic signed [W-1:0]   qb;
        logic signed [W-1:0]   q;
        logic signed [W-1:0]   r;
        case (op)
            2'b00: begin
                sa  = {{W{a[W-1]}}, a};
                sbv = {{W{b[W-1]}}, b};
                return sa * sbv;
            end
            2'b01: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            2'b10: begin
                if (b == {W{1'b0}}) return {a, {W{1'b1}}};
                if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {{W{1'b0}}, a};
                qa = a;
                qb = b;
                q  = qa / qb;
                r  = qa % qb;
                return {r, q};
            end
            default: begin
                if (b == {W{1'b0}}) return {a, {W{1'b1}}};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Edges from the start-sampling edge up to and including the edge after which done is high.
    function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
        logic [W-1:0] m;
        int           top;
        if (op[1]) begin
            if (b == {W{1'b0}}) return 2;
            return W + 2;
        end
        m   = (!op[0] && b[W-1]) ? -b : b;
        top = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) top = i;
        end
        return top + 3;
`else
        if (op[1] || b[0] || !b[0]) return W + 2;
        return W + 2;
`endif
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always begin
        @(posedge CLK);
        #1;
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {63'b0, bus.done}, 64'd0);
            end else begin
                logic [2*W-1:0] e;
                e = sb_q.pop_front();
                check("result_hi", {32'b0, bus.hi}, {32'b0, e[2*W-1:W]});
                check("result_lo", {32'b0, bus.lo}, {32'b0, e[W-1:0]});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input bit expect_done);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (expect_done) sb_q.push_back(exp);
    endtask

    // Waits for done after an issue; poke>0 pulses start+lo_wen during busy at that cycle.
    task automatic wait_done(input int lat, input int poke);
        int edges    = 0;
        int busy_cnt = 0;
        bit seen     = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            edges++;
            if (i == 0) begin
                bus.start = 1'b0;
                check("done_pulse_width", {63'b0, bus.done}, 64'd0);
                if (bus.lo_wen) begin
                    check("same_edge_write", {32'b0, bus.lo}, {32'b0, bus.wdat});
                    bus.lo_wen = 1'b0;
                end
                // Operands change after capture; result must not follow.
                bus.a  = $urandom;
                bus.b  = $urandom;
                bus.op = 2'($urandom_range(0, 3));
            end
            if (poke > 0 && i == poke) begin
                bus.start  = 1'b1;
                bus.lo_wen = 1'b1;
                bus.wdat   = 32'h0000ABCD;
            end
            if (poke > 0 && i == poke + 1) begin
                bus.start  = 1'b0;
                bus.lo_wen = 1'b0;
                check("lo_wen_while_busy", {32'b0, bus.lo}, 64'h5555);
            end
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        check("done_seen", {63'b0, seen}, 64'd1);
        check("latency", 64'(edges), 64'(lat));
        check("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           done_cnt;

        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.a      = 32'h0;
        bus.b      = 32'h0;
        bus.flush  = 1'b0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        bus.wdat   = 32'h0;
        RST        = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("reset_busy", {63'b0, bus.busy}, 64'd0);
        check("reset_done", {63'b0, bus.done}, 64'd0);
        check("reset_hi", {32'b0, bus.hi}, 64'd0);
        check("reset_lo", {32'b0, bus.lo}, 64'd0);

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{2'b01, 32'h00000010, 32'h00000003, 32'h00000000, 32'h00000030};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
        vecs[10] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        vecs[11] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

        // Directed table, issued back-to-back: each start lands in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b1);
            wait_done(exp_latency(vecs[i].op, vecs[i].b), 0);
        end

        // Random operations checked against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            issue(rop, ra, rb, model(rop, ra, rb), 1'b1);
            wait_done(exp_latency(rop, rb), 0);
        end
        tick();

        // Same-edge MTLO with start, then start+MTLO while busy are both ignored.
        bus.lo_wen = 1'b1;
        bus.wdat   = 32'h00005555;
        issue(2'b01, 32'h6, 32'h7, 64'd42, 1'b1);
        wait_done(exp_latency(2'b01, 32'h7), 1);
        repeat (40) tick();
        check("idle_after_ignored_start", {63'b0, bus.busy}, 64'd0);

        // MTHI and MTLO on the same edge.
        bus.hi_wen = 1'b1;
        bus.lo_wen = 1'b1;
        bus.wdat   = 32'h00001234;
        tick();
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        check("mthi", {32'b0, bus.hi}, 64'h1234);
        check("mtlo", {32'b0, bus.lo}, 64'h1234);

        // start together with flush in IDLE is dropped.
        issue(2'b00, 32'h5, 32'h40000000, 64'd0, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_with_flush_dropped", {63'b0, bus.busy}, 64'd0);

        // Flush at the 10th busy cycle: no done, HI/LO untouched.
        issue(2'b00, 32'h5, 32'h40000000, 64'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        check("busy_before_flush", {63'b0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy_low", {63'b0, bus.busy}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("flush_no_done", 64'(done_cnt), 64'd0);
        check("flush_hi_kept", {32'b0, bus.hi}, 64'h1234);

        // Asynchronous reset mid-CALC clears outputs immediately.
        issue(2'b01, 32'h0000FFFF, 32'h80000000, 64'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
        #1;
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_hi", {32'b0, bus.hi}, 64'd0);
        check("rst_lo", {32'b0, bus.lo}, 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Recovery after reset.
        issue(vecs[0].op, vecs[0].a, vecs[0].b, {vecs[0].hi, vecs[0].lo}, 1'b1);
        wait_done(exp_latency(vecs[0].op, vecs[0].b), 0);
        repeat (3) tick();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
